ecc_pingpong_frame_buffer: RTL and testbench

- Successor to the single-bank ADC/SA symbol collector that feeds the NB-LDPC decoder front end.
- Gathers PARALLEL lanes of ADC (CIM mode) or sense-amp (memory mode) samples over PERIOD CE strobes into one codeword frame.
- Double-buffers frames in two ping-pong banks, so acquisition of frame k+1 overlaps decoding of frame k.
- Hands each frame to the LLR/decoder stage through a valid/ready handshake, with a per-frame latched mode and a sticky overflow flag.

---
 rtl/ecc_pingpong_frame_buffer.sv | 168 ++++++++++++++++
 tb/tb_ecc_pingpong_frame_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_pingpong_frame_buffer.sv
// Purpose: collects PARALLEL-lane ADC/SA samples into PERIOD-word codeword frames, double-buffered in two ping-pong banks.
// Latency: a frame is presented the cycle after its last word is written if its bank is the read bank, else the cycle after the prior frame is released.
// Backpressure: the consumer stalls with FRAME_READY=0; with both banks full, incoming samples are dropped and OVERFLOW is set until reset.
module ecc_pingpong_frame_buffer #(
  parameter int INFO_GROUP  = 8,
  parameter int CHECK_GROUP = 2,
  parameter int PARALLEL    = 10,
  parameter int ADC_BIT     = 3,
  parameter int PERIOD      = 32,
  parameter int COUNTER_BIT = 5
) (
  input  logic                                   ADC_CLK,
  input  logic                                   SYS_RST,
  input  logic                                   CE,
  input  logic                                   CIM_E,
  input  logic [PARALLEL*ADC_BIT-1:0]            ADC_OUT,
  input  logic                                   FRAME_READY,
  output logic                                   FRAME_VALID,
  output logic                                   FRAME_MODE,
  output logic [PERIOD*INFO_GROUP*ADC_BIT-1:0]   ECC_SYMBOL_OUT,
  output logic [PERIOD*CHECK_GROUP*ADC_BIT-1:0]  ECC_CHECK_OUT,
  output logic [COUNTER_BIT-1:0]                 WR_COUNT,
  output logic                                   OVERFLOW
);

  localparam int                     WORD_W    = PARALLEL * ADC_BIT;
  localparam logic [COUNTER_BIT-1:0] LAST_WORD = COUNTER_BIT'(PERIOD - 1);

  // Parameter sanity: lane split must cover the word, and the counter must reach the last word.
  if (PARALLEL != INFO_GROUP + CHECK_GROUP) begin : g_bad_lane_split
    $error("PARALLEL must equal INFO_GROUP + CHECK_GROUP");
  end
  if (PERIOD < 2) begin : g_bad_period
    $error("PERIOD must be at least 2");
  end
  if (COUNTER_BIT < $clog2(PERIOD)) begin : g_bad_counter
    $error("COUNTER_BIT too narrow for PERIOD");
  end

  // Bank storage (not reset: a bank is only read after it has been completely rewritten).
  logic [WORD_W-1:0] mem_q [0:1][0:PERIOD-1];

  // Control state.
  logic                   wr_bank_q,   wr_bank_d;
  logic                   rd_bank_q,   rd_bank_d;
  logic [1:0]             full_q,      full_d;
  logic [1:0]             bank_mode_q, bank_mode_d;
  logic [COUNTER_BIT-1:0] wr_cnt_q,    wr_cnt_d;
  logic                   cur_mode_q,  cur_mode_d;
  logic                   ovf_q,       ovf_d;

  // Datapath / decode helpers.
  logic              eff_mode;
  logic [WORD_W-1:0] fmt_word;
  logic              wr_en;
  logic              drop;
  logic              last_word;
  logic              release_frm;

  // Lane formatting: mode is taken live on word 0, then frozen for the rest of the frame.
  always_comb begin
    eff_mode = (wr_cnt_q == '0) ? CIM_E : cur_mode_q;
    fmt_word = '0;
    for (int l = 0; l < PARALLEL; l++) begin
      if (eff_mode) begin
        fmt_word[l*ADC_BIT +: ADC_BIT] = ADC_OUT[l*ADC_BIT +: ADC_BIT];
      end else begin
        fmt_word[l*ADC_BIT +: ADC_BIT] = ADC_BIT'(ADC_OUT[l*ADC_BIT]);
      end
    end
  end

  // Write/read event decode; full status is the pre-edge value, so a release never frees room for a same-cycle sample.
  always_comb begin
    wr_en       = CE & ~full_q[wr_bank_q];
    drop        = CE &  full_q[wr_bank_q];
    last_word   = (wr_cnt_q == LAST_WORD);
    release_frm = full_q[rd_bank_q] & FRAME_READY;
  end

  // Next-state logic for bank pointers, full flags, word counter, mode latch and overflow.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    bank_mode_d = bank_mode_q;
    wr_cnt_d    = wr_cnt_q;
    cur_mode_d  = cur_mode_q;
    ovf_d       = ovf_q;

    if (wr_en) begin
      if (wr_cnt_q == '0) begin
        cur_mode_d = CIM_E;
      end
      if (last_word) begin
        full_d[wr_bank_q]      = 1'b1;
        bank_mode_d[wr_bank_q] = eff_mode;
        wr_bank_d              = ~wr_bank_q;
        wr_cnt_d               = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + COUNTER_BIT'(1);
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    // Release targets the read bank, which is full and therefore never the bank being written.
    if (release_frm) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control registers with synchronous reset; reset discards any partial or pending frame.
  always_ff @(posedge ADC_CLK) begin
    if (SYS_RST) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      bank_mode_q <= 2'b00;
      wr_cnt_q    <= '0;
      cur_mode_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      wr_cnt_q    <= wr_cnt_d;
      cur_mode_q  <= cur_mode_d;
      ovf_q       <= ovf_d;
    end
  end

  // Sample capture into the bank currently being filled.
  always_ff @(posedge ADC_CLK) begin
    if (!SYS_RST && wr_en) begin
      mem_q[wr_bank_q][wr_cnt_q] <= fmt_word;
    end
  end

  // Frame presentation: unpack the read bank into info/check symbol buses, zero while nothing is presented.
  always_comb begin
    ECC_SYMBOL_OUT = '0;
    ECC_CHECK_OUT  = '0;
    FRAME_MODE     = 1'b0;
    if (full_q[rd_bank_q]) begin
      FRAME_MODE = bank_mode_q[rd_bank_q];
      for (int e = 0; e < PERIOD; e++) begin
        for (int g = 0; g < INFO_GROUP; g++) begin
          ECC_SYMBOL_OUT[(e*INFO_GROUP+g)*ADC_BIT +: ADC_BIT] =
            mem_q[rd_bank_q][e][g*ADC_BIT +: ADC_BIT];
        end
        for (int c = 0; c < CHECK_GROUP; c++) begin
          ECC_CHECK_OUT[(e*CHECK_GROUP+c)*ADC_BIT +: ADC_BIT] =
            mem_q[rd_bank_q][e][(INFO_GROUP+c)*ADC_BIT +: ADC_BIT];
        end
      end
    end
  end

  assign FRAME_VALID = full_q[rd_bank_q];
  assign WR_COUNT    = wr_cnt_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_ecc_pingpong_frame_buffer.sv
// Purpose: directed self-checking bench for the ping-pong ECC frame buffer.
// Latency: expects a completed frame to be visible the cycle after its last write when its bank is the read bank.
// Backpressure: exercises FRAME_READY stalls, two-frame buffering, overflow drops and ready-while-idle.
module tb_ecc_pingpong_frame_buffer;

  logic         clk;
  logic         rst;
  logic         ce;
  logic         cim_e;
  logic [29:0]  adc_out;
  logic         frame_ready;
  logic         frame_valid;
  logic         frame_mode;
  logic [767:0] sym_out;
  logic [191:0] chk_out;
  logic [4:0]   wr_count;
  logic         overflow;

  int checks   = 0;
  int failures = 0;
  int vcount;

  ecc_pingpong_frame_buffer dut (
    .ADC_CLK        (clk),
    .SYS_RST        (rst),
    .CE             (ce),
    .CIM_E          (cim_e),
    .ADC_OUT        (adc_out),
    .FRAME_READY    (frame_ready),
    .FRAME_VALID    (frame_valid),
    .FRAME_MODE     (frame_mode),
    .ECC_SYMBOL_OUT (sym_out),
    .ECC_CHECK_OUT  (chk_out),
    .WR_COUNT       (wr_count),
    .OVERFLOW       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane pattern generator: p0 = word index mod 8 on all lanes, p1 = 110/111 alternating, p2 = (3e+l) mod 8.
  function automatic logic [2:0] lane_val(int p, int e, int l);
    if (p == 0) return 3'(e % 8);
    if (p == 1) return (e % 2 == 1) ? 3'b111 : 3'b110;
    return 3'((e*3 + l) % 8);
  endfunction

  function automatic logic [29:0] gen_word(int p, int e);
    logic [29:0] w;
    w = '0;
    for (int l = 0; l < 10; l++) w[l*3 +: 3] = lane_val(p, e, l);
    return w;
  endfunction

  function automatic logic [2:0] fmt(logic [2:0] v, logic mode);
    return mode ? v : {2'b00, v[0]};
  endfunction

  function automatic logic [767:0] exp_sym(int p, logic mode);
    logic [767:0] r;
    r = '0;
    for (int e = 0; e < 32; e++)
      for (int g = 0; g < 8; g++)
        r[(e*8+g)*3 +: 3] = fmt(lane_val(p, e, g), mode);
    return r;
  endfunction

  function automatic logic [191:0] exp_chk(int p, logic mode);
    logic [191:0] r;
    r = '0;
    for (int e = 0; e < 32; e++)
      for (int c = 0; c < 2; c++)
        r[(e*2+c)*3 +: 3] = fmt(lane_val(p, e, 8+c), mode);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int p, int e, logic mode);
    ce      = 1'b1;
    cim_e   = mode;
    adc_out = gen_word(p, e);
    tick();
    ce      = 1'b0;
  endtask

  task automatic push_frame(int p, logic mode);
    for (int e = 0; e < 32; e++) push(p, e, mode);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; cim_e = 1'b0; adc_out = '0; frame_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", frame_valid, 1'b0);
    check("rst_wrcnt", wr_count, 5'd0);
    check("rst_ovf",   overflow, 1'b0);
    check("rst_mode",  frame_mode, 1'b0);
    check("rst_sym",   sym_out, '0);

    // CIM frame, lane value = word index mod 8
    for (int e = 0; e < 31; e++) push(0, e, 1'b1);
    check("t1_valid_early", frame_valid, 1'b0);
    check("t1_wrcnt31", wr_count, 5'd31);
    push(0, 31, 1'b1);
    check("t1_valid", frame_valid, 1'b1);
    check("t1_wrcnt0", wr_count, 5'd0);
    check("t1_mode", frame_mode, 1'b1);
    check("t1_w5l3", sym_out[43*3 +: 3], 3'd5);
    check("t1_chk11", chk_out[11*3 +: 3], 3'd5);
    check("t1_sym", sym_out, exp_sym(0, 1'b1));
    check("t1_chk", chk_out, exp_chk(0, 1'b1));
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t1_released", frame_valid, 1'b0);
    check("t1_sym_zero", sym_out, '0);

    // SA frame with CIM_E toggling to 1 at word 10: whole frame stays SA format
    for (int e = 0; e < 32; e++) push(1, e, (e >= 10));
    check("t2_valid", frame_valid, 1'b1);
    check("t2_mode", frame_mode, 1'b0);
    check("t2_sym", sym_out, exp_sym(1, 1'b0));
    check("t2_chk", chk_out, exp_chk(1, 1'b0));
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t2_released", frame_valid, 1'b0);

    // Two frames buffered, then overflow
    push_frame(2, 1'b1);
    push_frame(0, 1'b0);
    check("t3_valid", frame_valid, 1'b1);
    check("t3_ovf0", overflow, 1'b0);
    check("t3_symA", sym_out, exp_sym(2, 1'b1));
    check("t3_modeA", frame_mode, 1'b1);
    push(1, 0, 1'b1);
    check("t3_ovf1", overflow, 1'b1);
    check("t3_wrcnt_hold", wr_count, 5'd0);
    check("t3_symA_hold", sym_out, exp_sym(2, 1'b1));
    // Release together with a sample: the sample is still dropped
    frame_ready = 1'b1;
    ce = 1'b1; cim_e = 1'b1; adc_out = gen_word(1, 0);
    tick();
    ce = 1'b0;
    frame_ready = 1'b0;
    check("t3_valid_b2b", frame_valid, 1'b1);
    check("t3_symB", sym_out, exp_sym(0, 1'b0));
    check("t3_chkB", chk_out, exp_chk(0, 1'b0));
    check("t3_modeB", frame_mode, 1'b0);
    check("t3_drop_on_release", wr_count, 5'd0);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    check("t3_empty", frame_valid, 1'b0);
    check("t3_ovf_sticky", overflow, 1'b1);

    // Continuous streaming with an always-ready consumer
    do_reset();
    check("t4_ovf_cleared", overflow, 1'b0);
    frame_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 96; i++) begin
      ce = 1'b1; cim_e = 1'b1; adc_out = gen_word(0, i % 32);
      tick();
      if (frame_valid) begin
        vcount++;
        check("t4_data", sym_out, exp_sym(0, 1'b1));
      end
    end
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (frame_valid) vcount++;
    end
    frame_ready = 1'b0;
    check("t4_pulses", vcount, 3);
    check("t4_no_drop", overflow, 1'b0);
    check("t4_wrcnt", wr_count, 5'd0);

    // Reset in the middle of a frame with one frame pending
    push_frame(0, 1'b1);
    for (int e = 0; e < 17; e++) push(1, e, 1'b1);
    check("t5_wrcnt17", wr_count, 5'd17);
    check("t5_pending", frame_valid, 1'b1);
    rst = 1'b1; ce = 1'b1; adc_out = gen_word(1, 17);
    tick();
    rst = 1'b0; ce = 1'b0;
    check("t5_valid0", frame_valid, 1'b0);
    check("t5_wrcnt0", wr_count, 5'd0);
    check("t5_sym0", sym_out, '0);
    check("t5_mode0", frame_mode, 1'b0);
    push_frame(2, 1'b0);
    check("t5_clean_valid", frame_valid, 1'b1);
    check("t5_clean_sym", sym_out, exp_sym(2, 1'b0));
    check("t5_clean_chk", chk_out, exp_chk(2, 1'b0));
    check("t5_clean_mode", frame_mode, 1'b0);

    // FRAME_READY while nothing is presented is ignored
    frame_ready = 1'b1;
    tick();
    check("t6_released", frame_valid, 1'b0);
    tick();
    tick();
    tick();
    frame_ready = 1'b0;
    check("t6_idle_valid", frame_valid, 1'b0);
    check("t6_idle_wrcnt", wr_count, 5'd0);
    push_frame(1, 1'b1);
    check("t6_valid", frame_valid, 1'b1);
    check("t6_sym", sym_out, exp_sym(1, 1'b1));
    check("t6_mode", frame_mode, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
